ld_alu: RTL and testbench



---
 rtl/ld_alu_if.sv | 12 +
 rtl/ld_alu.sv | 84 ++++++++
 tb/tb_ld_alu.sv | 138 +++++++++++++
 3 files changed

// File: rtl/ld_alu_if.sv
// Operand/result bundle for the LD-coordinate point ALU over GF(2^4).
// Points are packed {Z[11:8], Y[7:4], X[3:0]}.
`timescale 1ns/1ps
interface ld_alu_if;
  logic        op;
  logic [11:0] A;
  logic [11:0] B;
  logic [11:0] R;

  modport master (output op, output A, output B, input R);
  modport slave  (input op, input A, input B, output R);
endinterface

// File: rtl/ld_alu.sv
// Lopez-Dahab point ALU for y^2 + xy = x^3 + a*x^2 + b over GF(2^4), poly x^4 + x + 1.
// Computes mixed addition (op=0) or doubling (op=1) combinationally; result is registered.
`timescale 1ns/1ps
module ld_alu (
  input  logic     clk,
  input  logic     n_rst,
  ld_alu_if.slave  bus
);

  localparam logic [3:0] CurveA = 4'h4;
  localparam logic [3:0] CurveB = 4'h1;

  // Carry-less 4x4 product folded back with alpha^4 = alpha + 1.
  function automatic logic [3:0] gf_mul(input logic [3:0] x, input logic [3:0] y);
    logic [6:0] p;
    p = '0;
    for (int i = 0; i < 4; i++) begin
      if (y[i]) p = p ^ ({3'b000, x} << i);
    end
    for (int i = 6; i >= 4; i--) begin
      if (p[i]) p = p ^ (7'h13 << (i - 4));
    end
    return p[3:0];
  endfunction

  function automatic logic [3:0] gf_sq(input logic [3:0] x);
    return gf_mul(x, x);
  endfunction

  // Doubling operands come from A.
  logic [3:0] dx1, dy1, dz1;
  logic [3:0] d_x1s, d_z1s, d_bz4;
  logic [3:0] dbl_x, dbl_y, dbl_z;

  assign dx1 = bus.A[3:0];
  assign dy1 = bus.A[7:4];
  assign dz1 = bus.A[11:8];

  assign d_x1s = gf_sq(dx1);
  assign d_z1s = gf_sq(dz1);
  assign d_bz4 = gf_mul(CurveB, gf_sq(d_z1s));
  assign dbl_z = gf_mul(d_x1s, d_z1s);
  assign dbl_x = gf_sq(d_x1s) ^ d_bz4;
  assign dbl_y = gf_mul(d_bz4, dbl_z)
               ^ gf_mul(dbl_x, gf_mul(CurveA, dbl_z) ^ gf_sq(dy1) ^ d_bz4);

  // Mixed addition: affine (x2, y2) from A with A.Z taken as 1, projective point from B.
  logic [3:0] x2, y2, ax1, ay1, az1;
  logic [3:0] a_z1s, t_a, t_b, c_t, d_t, e_t, f_t, g_t;
  logic [3:0] add_x, add_y, add_z;

  assign x2  = bus.A[3:0];
  assign y2  = bus.A[7:4];
  assign ax1 = bus.B[3:0];
  assign ay1 = bus.B[7:4];
  assign az1 = bus.B[11:8];

  assign a_z1s = gf_sq(az1);
  assign t_a   = gf_mul(y2, a_z1s) ^ ay1;
  assign t_b   = gf_mul(x2, az1) ^ ax1;
  assign c_t   = gf_mul(az1, t_b);
  assign d_t   = gf_mul(gf_sq(t_b), c_t ^ gf_mul(CurveA, a_z1s));
  assign e_t   = gf_mul(t_a, c_t);
  assign add_z = gf_sq(c_t);
  assign add_x = gf_sq(t_a) ^ d_t ^ e_t;
  assign f_t   = add_x ^ gf_mul(x2, add_z);
  assign g_t   = gf_mul(x2 ^ y2, gf_sq(add_z));
  assign add_y = gf_mul(e_t ^ add_z, f_t) ^ g_t;

  logic [11:0] r_d, r_q;

  always_comb begin
    r_d = {add_z, add_y, add_x};
    if (bus.op) r_d = {dbl_z, dbl_y, dbl_x};
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_q <= '0;
    else        r_q <= r_d;
  end

  assign bus.R = r_q;

endmodule

// File: tb/tb_ld_alu.sv
// Bench for ld_alu: directed vectors from known curve points plus random operands
// checked against a log/antilog-table field model.
`timescale 1ns/1ps
module tb_ld_alu;

  logic tb_clk;
  logic n_rst;
  int   n_tests;
  int   n_fail;

  ld_alu_if bus ();

  ld_alu dut (
    .clk   (tb_clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  int exp_t [15];
  int log_t [16];

  function automatic int fmul(input int x, input int y);
    if (x == 0 || y == 0) return 0;
    return exp_t[(log_t[x] + log_t[y]) % 15];
  endfunction

  // Curve formulas evaluated with table-based field multiplication.
  function automatic logic [11:0] model_r(input logic op, input logic [11:0] a,
                                          input logic [11:0] b);
    int x1, y1, z1, x2, y2, x3, y3, z3, bz4, ta, tb, c, d, e, f, g;
    if (op) begin
      x1 = int'(a[3:0]); y1 = int'(a[7:4]); z1 = int'(a[11:8]);
      z3  = fmul(fmul(x1, x1), fmul(z1, z1));
      bz4 = fmul(1, fmul(fmul(z1, z1), fmul(z1, z1)));
      x3  = fmul(fmul(x1, x1), fmul(x1, x1)) ^ bz4;
      y3  = fmul(bz4, z3) ^ fmul(x3, fmul(4, z3) ^ fmul(y1, y1) ^ bz4);
    end else begin
      x2 = int'(a[3:0]); y2 = int'(a[7:4]);
      x1 = int'(b[3:0]); y1 = int'(b[7:4]); z1 = int'(b[11:8]);
      ta = fmul(y2, fmul(z1, z1)) ^ y1;
      tb = fmul(x2, z1) ^ x1;
      c  = fmul(z1, tb);
      d  = fmul(fmul(tb, tb), c ^ fmul(4, fmul(z1, z1)));
      e  = fmul(ta, c);
      z3 = fmul(c, c);
      x3 = fmul(ta, ta) ^ d ^ e;
      f  = x3 ^ fmul(x2, z3);
      g  = fmul(x2 ^ y2, fmul(z3, z3));
      y3 = fmul(e ^ z3, f) ^ g;
    end
    return {z3[3:0], y3[3:0], x3[3:0]};
  endfunction

  task automatic check_eq(input string tag, input logic [11:0] got, input logic [11:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%03h expected 0x%03h", tag, got, want);
    end
  endtask

  task automatic drive(input logic op, input logic [11:0] a, input logic [11:0] b);
    bus.op = op;
    bus.A  = a;
    bus.B  = b;
  endtask

  task automatic step_check(input string tag, input logic [11:0] want);
    @(posedge tb_clk);
    #1;
    check_eq(tag, bus.R, want);
  endtask

  initial begin
    int v;
    logic        rop;
    logic [11:0] ra, rb;
    n_tests = 0;
    n_fail  = 0;

    v = 1;
    for (int k = 0; k < 15; k++) begin
      exp_t[k] = v;
      log_t[v] = k;
      v = v << 1;
      if (v & 16) v = v ^ 19;
    end
    log_t[0] = 0;

    n_rst = 1'b1;
    drive(1'b1, 12'hC2E, 12'h000);
    #2 n_rst = 1'b0;
    #1 check_eq("reset_async", bus.R, 12'h000);
    repeat (3) @(posedge tb_clk);
    #1 check_eq("reset_hold", bus.R, 12'h000);
    n_rst = 1'b1;
    #1 check_eq("reset_release_no_edge", bus.R, 12'h000);

    drive(1'b1, 12'h138, 12'h000);
    step_check("double_P", 12'hC2E);
    drive(1'b0, 12'h138, 12'hC2E);
    step_check("add_P_2P", 12'h227);
    drive(1'b0, 12'h538, 12'hC2E);
    step_check("add_ignores_AZ", 12'h227);
    drive(1'b1, 12'h038, 12'h000);
    step_check("double_Z0", 12'h06F);
    drive(1'b1, 12'h138, 12'hFFF);
    step_check("double_ignores_B", 12'hC2E);

    // Back-to-back with a reset pulse in the middle.
    drive(1'b1, 12'h138, 12'h000);
    step_check("b2b_double", 12'hC2E);
    drive(1'b0, 12'h138, 12'hC2E);
    step_check("b2b_add", 12'h227);
    drive(1'b1, 12'h138, 12'h000);
    n_rst = 1'b0;
    #1 check_eq("midstream_reset", bus.R, 12'h000);
    @(posedge tb_clk);
    #1 check_eq("midstream_reset_hold", bus.R, 12'h000);
    n_rst = 1'b1;
    step_check("after_reset_double", 12'hC2E);

    for (int i = 0; i < 300; i++) begin
      rop = 1'($urandom_range(0, 1));
      ra  = 12'($urandom);
      rb  = 12'($urandom);
      drive(rop, ra, rb);
      step_check(rop ? "rand_double" : "rand_add", model_r(rop, ra, rb));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
